// File: rtl/lcd_16x2_controller.sv
// lcd_16x2_controller: autonomous write-only HD44780 16x2 driver (8-bit mode).
// Sequence: power-up wait, 4 init commands, line-1 address + 16 chars,
// line-2 address + 16 chars, then DONE.
// Optional macro LCD_REFRESH_EN: DONE waits POWER_UP_TICKS ticks and then
// rewrites both lines forever. The init commands are not repeated.
module lcd_16x2_controller #(
    parameter int COUNT_MAX      = 1000000,
    parameter int POWER_UP_TICKS = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       rs,
    output logic       ena,
    output logic       rw,
    output logic [7:0] dat
);

    localparam int CNT_W  = $clog2(COUNT_MAX);
    localparam int WAIT_W = $clog2(POWER_UP_TICKS + 1);

    // Leftmost character sits in the most significant byte.
    localparam logic [127:0] LINE1_TEXT = "TAMAGOTCHI GRP01";
    localparam logic [127:0] LINE2_TEXT = "  HOLA MUNDO!   ";

    typedef enum logic [2:0] {
        ST_POWER_UP,
        ST_INIT,
        ST_LINE1_ADDR,
        ST_LINE1,
        ST_LINE2_ADDR,
        ST_LINE2,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        PH_SETUP,
        PH_PULSE,
        PH_HOLD
    } phase_e;

    logic [CNT_W-1:0]  cnt_q;
    logic              tick;
    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        char_q, char_d;
    logic              rs_q, rs_d;
    logic              ena_q, ena_d;
    logic [7:0]        dat_q, dat_d;

    logic              cur_rs;
    logic [7:0]        cur_byte;
    logic              last_byte;
    logic [6:0]        bit_base;
    logic              wait_done;

    assign tick      = (cnt_q == CNT_W'(COUNT_MAX - 1));
    assign wait_done = (wait_q == WAIT_W'(POWER_UP_TICKS - 1));
    // (15 - char) * 8: bit offset of the selected character in the text.
    assign bit_base  = {~char_q, 3'b000};

    // Clock-enable divider: one-cycle tick every COUNT_MAX clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // State register plus registered LCD outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_POWER_UP;
            phase_q <= PH_SETUP;
            wait_q  <= '0;
            char_q  <= '0;
            rs_q    <= 1'b0;
            ena_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            wait_q  <= wait_d;
            char_q  <= char_d;
            rs_q    <= rs_d;
            ena_q   <= ena_d;
            dat_q   <= dat_d;
        end
    end

    // Byte source: which byte/register the current state sends, and whether it is the last one.
    always_comb begin
        cur_rs    = 1'b0;
        cur_byte  = 8'h00;
        last_byte = 1'b1;
        case (state_q)
            ST_INIT: begin
                last_byte = (char_q == 4'd3);
                case (char_q[1:0])
                    2'd0:    cur_byte = 8'h38;
                    2'd1:    cur_byte = 8'h0C;
                    2'd2:    cur_byte = 8'h01;
                    default: cur_byte = 8'h06;
                endcase
            end
            ST_LINE1_ADDR: cur_byte = 8'h80;
            ST_LINE1: begin
                cur_rs    = 1'b1;
                cur_byte  = LINE1_TEXT[bit_base +: 8];
                last_byte = (char_q == 4'd15);
            end
            ST_LINE2_ADDR: cur_byte = 8'hC0;
            ST_LINE2: begin
                cur_rs    = 1'b1;
                cur_byte  = LINE2_TEXT[bit_base +: 8];
                last_byte = (char_q == 4'd15);
            end
            default: ;
        endcase
    end

    // Next-state logic: advances only on tick, three phases per byte.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        wait_d  = wait_q;
        char_d  = char_q;
        if (tick) begin
            case (state_q)
                ST_POWER_UP: begin
                    if (wait_done) begin
                        state_d = ST_INIT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                ST_DONE: begin
`ifdef LCD_REFRESH_EN
                    if (wait_done) begin
                        state_d = ST_LINE1_ADDR;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
`endif
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: phase_d = PH_PULSE;
                        PH_PULSE: phase_d = PH_HOLD;
                        default: begin
                            phase_d = PH_SETUP;
                            if (last_byte) begin
                                char_d = '0;
                                case (state_q)
                                    ST_INIT:       state_d = ST_LINE1_ADDR;
                                    ST_LINE1_ADDR: state_d = ST_LINE1;
                                    ST_LINE1:      state_d = ST_LINE2_ADDR;
                                    ST_LINE2_ADDR: state_d = ST_LINE2;
                                    default:       state_d = ST_DONE;
                                endcase
                            end else begin
                                char_d = char_q + 1'b1;
                            end
                        end
                    endcase
                end
            endcase
        end
    end

    // Output logic: bus loads on SETUP, strobe high on PULSE, low on HOLD; updates only on tick.
    always_comb begin
        rs_d  = rs_q;
        ena_d = ena_q;
        dat_d = dat_q;
        if (tick) begin
            case (state_q)
                ST_POWER_UP: begin
                    rs_d  = 1'b0;
                    ena_d = 1'b0;
                    dat_d = 8'h00;
                end
                ST_DONE: begin
                    rs_d  = 1'b0;
                    ena_d = 1'b0;
                end
                default: begin
                    case (phase_q)
                        PH_SETUP: begin
                            rs_d  = cur_rs;
                            dat_d = cur_byte;
                            ena_d = 1'b0;
                        end
                        PH_PULSE: ena_d = 1'b1;
                        default:  ena_d = 1'b0;
                    endcase
                end
            endcase
        end
    end

    assign rs  = rs_q;
    assign ena = ena_q;
    assign dat = dat_q;
    assign rw  = 1'b0;

endmodule

// File: tb/tb_lcd_16x2_controller.sv
// Testbench for lcd_16x2_controller with COUNT_MAX=10, POWER_UP_TICKS=20.
// A negedge monitor records each strobe (bus value at ena rise, pulse width,
// bus-stability violations); tasks compare against a scoreboard queue.
module tb_lcd_16x2_controller;

    localparam int CM  = 10;
    localparam int PUT = 20;

    logic       clk;
    logic       rst_n;
    logic       rs;
    logic       ena;
    logic       rw;
    logic [7:0] dat;

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic [8:0] obs_q[$];
    int         width_q[$];
    int         rise_cnt;
    int         bus_viol;
    int         hi_len;
    int         stable_cnt;
    int         since_fall;
    logic       ena_prev;
    logic [8:0] last_bus;

    lcd_16x2_controller #(
        .COUNT_MAX      (CM),
        .POWER_UP_TICKS (PUT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (rs),
        .ena   (ena),
        .rw    (rw),
        .dat   (dat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        logic [8:0] bus;
        bus = {rs, dat};
        if (!rst_n) begin
            obs_q.delete();
            width_q.delete();
            rise_cnt   = 0;
            bus_viol   = 0;
            hi_len     = 0;
            stable_cnt = 0;
            since_fall = 1000;
            ena_prev   = 1'b0;
            last_bus   = bus;
        end else begin
            if (bus !== last_bus) begin
                if (ena || ena_prev) bus_viol++;
                else if (since_fall < CM) bus_viol++;
                stable_cnt = 1;
            end else begin
                stable_cnt++;
            end
            last_bus = bus;
            if (ena && !ena_prev) begin
                rise_cnt++;
                obs_q.push_back(bus);
                if (stable_cnt < CM + 1) bus_viol++;
                hi_len = 0;
            end
            if (ena) hi_len++;
            if (!ena && ena_prev) begin
                width_q.push_back(hi_len);
                since_fall = 1;
            end else if (since_fall < 1000) begin
                since_fall++;
            end
            ena_prev = ena;
        end
    end

    task automatic test_reset();
        int highs = 0;
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (rs !== 1'b0) begin failures++; $display("FAIL reset_rs got=%b exp=0", rs); end
        checks++; if (ena !== 1'b0) begin failures++; $display("FAIL reset_ena got=%b exp=0", ena); end
        checks++; if (rw !== 1'b0) begin failures++; $display("FAIL reset_rw got=%b exp=0", rw); end
        checks++; if (dat !== 8'h00) begin failures++; $display("FAIL reset_dat got=%02h exp=00", dat); end
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ena !== 1'b0) highs++;
        end
        checks++; if (highs !== 0) begin failures++; $display("FAIL power_up_quiet ena_high_cycles=%0d exp=0", highs); end
        $display("reset: outputs checked, ena low for 200 clk after release");
    endtask

    task automatic test_stream(input string tag);
        string      l1 = "TAMAGOTCHI GRP01";
        string      l2 = "  HOLA MUNDO!   ";
        logic [7:0] c;
        logic [8:0] got;
        logic [8:0] expv;
        int         t;
        int         bad_w;
        exp_q.delete();
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
        exp_q.push_back(9'h080);
        for (int i = 0; i < 16; i++) begin c = l1[i]; exp_q.push_back({1'b1, c}); end
        exp_q.push_back(9'h0C0);
        for (int i = 0; i < 16; i++) begin c = l2[i]; exp_q.push_back({1'b1, c}); end
        for (int n = 0; n < 38; n++) begin
            t = 0;
            while (obs_q.size() == 0 && t < 400) begin @(negedge clk); t++; end
            if (obs_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL %s_timeout byte=%0d no strobe within 400 clk", tag, n);
                break;
            end
            got  = obs_q.pop_front();
            expv = exp_q.pop_front();
            checks++;
            if (got !== expv) begin
                failures++;
                $display("FAIL %s_byte%0d got rs=%b dat=%02h exp rs=%b dat=%02h",
                         tag, n, got[8], got[7:0], expv[8], expv[7:0]);
            end
            $display("%s byte %0d: rs=%b dat=%02h (exp rs=%b dat=%02h)",
                     tag, n, got[8], got[7:0], expv[8], expv[7:0]);
        end
        t = 0;
        while (width_q.size() < 38 && t < 100) begin @(negedge clk); t++; end
        repeat (40) @(negedge clk);
        checks++;
        if (width_q.size() != 38) begin
            failures++;
            $display("FAIL %s_pulse_count got=%0d exp=38", tag, width_q.size());
        end
        bad_w = 0;
        foreach (width_q[i]) if (width_q[i] != CM) bad_w++;
        checks++; if (bad_w !== 0) begin failures++; $display("FAIL %s_pulse_width bad_pulses=%0d exp=0 (width must be %0d)", tag, bad_w, CM); end
        checks++; if (bus_viol !== 0) begin failures++; $display("FAIL %s_bus_stability violations=%0d exp=0", tag, bus_viol); end
        checks++; if (rise_cnt !== 38) begin failures++; $display("FAIL %s_rise_count got=%0d exp=38", tag, rise_cnt); end
        $display("%s: %0d pulses, widths checked, stability violations=%0d", tag, width_q.size(), bus_viol);
    endtask

    task automatic test_done_quiet();
`ifdef LCD_REFRESH_EN
        int         t = 0;
        logic [8:0] got;
        while (obs_q.size() == 0 && t < 1000) begin @(negedge clk); t++; end
        checks++;
        if (obs_q.size() == 0) begin
            failures++;
            $display("FAIL refresh_timeout no strobe within 1000 clk after DONE");
        end else begin
            got = obs_q.pop_front();
            if (got !== 9'h080) begin
                failures++;
                $display("FAIL refresh_addr got rs=%b dat=%02h exp rs=0 dat=80", got[8], got[7:0]);
            end
            $display("refresh: first byte rs=%b dat=%02h (exp rs=0 dat=80)", got[8], got[7:0]);
        end
`else
        repeat (1000) @(negedge clk);
        checks++; if (rise_cnt !== 38) begin failures++; $display("FAIL done_no_pulses total=%0d exp=38", rise_cnt); end
        checks++; if (ena !== 1'b0) begin failures++; $display("FAIL done_ena got=%b exp=0", ena); end
        checks++; if (rs !== 1'b0) begin failures++; $display("FAIL done_rs got=%b exp=0", rs); end
        checks++; if (dat !== 8'h20) begin failures++; $display("FAIL done_dat got=%02h exp=20", dat); end
        $display("done: %0d pulses total, ena=%b rs=%b dat=%02h", rise_cnt, ena, rs, dat);
`endif
    endtask

    task automatic test_mid_reset();
        int t = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        while (!(rise_cnt == 10 && ena === 1'b1) && t < 2000) begin @(negedge clk); t++; end
        checks++;
        if (!(rise_cnt == 10 && ena === 1'b1)) begin
            failures++;
            $display("FAIL mid_reset_wait tenth pulse not seen (rises=%0d)", rise_cnt);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ena !== 1'b0) begin failures++; $display("FAIL mid_reset_ena got=%b exp=0", ena); end
        checks++; if (dat !== 8'h00) begin failures++; $display("FAIL mid_reset_dat got=%02h exp=00", dat); end
        $display("mid_reset: asserted during pulse 10, ena=%b dat=%02h", ena, dat);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        test_stream("restart");
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset();
        test_stream("first");
        test_done_quiet();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
